// File: rtl/dac_spi_pkg.sv
// Shared constants, FSM encoding and sample/frame helpers for the
// ADC -> LTC2624 DAC loopback writer.
package dac_spi_pkg;

  localparam int FRAME_W = 32;
  localparam int ADC_W   = 14;
  localparam int DAC_W   = 12;

  localparam logic [3:0] DAC_CMD_DEF  = 4'b0011;  // write to and update
  localparam logic [3:0] DAC_ADDR_DEF = 4'b1111;  // all channels

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SCK_HI,
    ST_SCK_LO,
    ST_GAP
  } state_e;

  // Two's complement -> offset binary: flip the sign bit, drop the 2 LSBs.
  function automatic logic [DAC_W-1:0] sample_to_code(input logic [ADC_W-1:0] s);
    return {~s[ADC_W-1], s[ADC_W-2:2]};
  endfunction

  // 32-bit LTC2624 word, bit 31 shifted first.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [3:0]       cmd,
                                                      input logic [3:0]       addr,
                                                      input logic [DAC_W-1:0] code);
    return {8'h00, cmd, addr, code, 4'h0};
  endfunction

endpackage

// File: rtl/spi_tx_shift32.sv
// 32-bit MSB-first shift register with SCK half-period divider and bit
// counter. Sequencing is owned by the parent FSM through load/shift/reload.
module spi_tx_shift32
  import dac_spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,      // capture frame_i, clear bit counter
  input  logic               shift_i,     // advance to next bit
  input  logic               reload_i,    // restart divider (state change)
  input  logic               long_i,      // reload with the 2*D gap length
  input  logic [FRAME_W-1:0] frame_i,
  output logic               mosi_o,
  output logic               div_done_o,  // last cycle of current interval
  output logic               last_bit_o   // all 32 bits have been shifted
);

  localparam logic [8:0] HALF_RL = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_RL  = 9'(2 * CLK_DIV - 1);

  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [8:0]         div_q,   div_d;
  logic [4:0]         bit_q,   bit_d;
  logic               term_q,  term_d;

  // Next-state: shift register fills with zeros so MOSI idles low after bit 0;
  // bit counter saturates at 31 and raises the terminal flag instead of wrapping.
  always_comb begin
    shreg_d = shreg_q;
    bit_d   = bit_q;
    term_d  = term_q;
    div_d   = div_q;
    if (load_i) begin
      shreg_d = frame_i;
      bit_d   = '0;
      term_d  = 1'b0;
    end else if (shift_i) begin
      shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
      if (bit_q == 5'd31) term_d = 1'b1;
      else                bit_d  = bit_q + 5'd1;
    end
    if (reload_i)          div_d = long_i ? GAP_RL : HALF_RL;
    else if (div_q != '0)  div_d = div_q - 9'd1;
  end

  // State registers, cleared by the synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      term_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      term_q  <= term_d;
    end
  end

  assign mosi_o     = shreg_q[FRAME_W-1];
  assign div_done_o = (div_q == '0);
  assign last_bit_o = term_q;

endmodule

// File: rtl/dac_sample_writer.sv
// Accepts one ADC sample per valid/ready handshake, converts it to 12-bit
// offset binary and shifts a write-and-update frame to the LTC2624 DAC.
module dac_sample_writer
  import dac_spi_pkg::*;
#(
  parameter int         CLK_DIV  = 2,
  parameter logic [3:0] DAC_CMD  = DAC_CMD_DEF,
  parameter logic [3:0] DAC_ADDR = DAC_ADDR_DEF
) (
  input  logic        clock_in,
  input  logic        reset,
  input  logic [13:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        dac_cs,
  output logic        dac_sck,
  output logic        dac_mosi,
  output logic        dac_clr,
  output logic        busy,
  output logic        frame_done
);

  state_e state_q;
  logic   ready_q, cs_q, sck_q, clr_q, busy_q, done_q;

  logic               accept, div_done, last_bit, sh_shift, sh_reload, sh_long;
  logic [FRAME_W-1:0] frame;

  assign accept    = (state_q == ST_IDLE) && ready_q && sample_valid;
  assign frame     = build_frame(DAC_CMD, DAC_ADDR, sample_to_code(sample_in));
  // Bit advances on the falling SCK edge, i.e. leaving SCK_HI.
  assign sh_shift  = (state_q == ST_SCK_HI) && div_done;
  // Divider restarts on every state change.
  assign sh_reload = accept || ((state_q != ST_IDLE) && div_done);
  assign sh_long   = (state_q == ST_SCK_LO) && last_bit;

  spi_tx_shift32 #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk_i      (clock_in),
    .rst_i      (reset),
    .load_i     (accept),
    .shift_i    (sh_shift),
    .reload_i   (sh_reload),
    .long_i     (sh_long),
    .frame_i    (frame),
    .mosi_o     (dac_mosi),
    .div_done_o (div_done),
    .last_bit_o (last_bit)
  );

  // Frame sequencer; every output is a register updated with the transition.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      clr_q  <= 1'b1;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_SETUP;
            cs_q    <= 1'b0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_SETUP: if (div_done) begin
          state_q <= ST_SCK_HI;
          sck_q   <= 1'b1;
        end
        ST_SCK_HI: if (div_done) begin
          state_q <= ST_SCK_LO;
          sck_q   <= 1'b0;
        end
        ST_SCK_LO: if (div_done) begin
          if (last_bit) begin
            state_q <= ST_GAP;
            cs_q    <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_SCK_HI;
            sck_q   <= 1'b1;
          end
        end
        ST_GAP: if (div_done) begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sample_ready = ready_q;
  assign dac_cs       = cs_q;
  assign dac_sck      = sck_q;
  assign dac_clr      = clr_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_dac_sample_writer.sv
// Bench for dac_sample_writer: u0 at CLK_DIV=2, u1 at CLK_DIV=1.
module tb_dac_sample_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, vld;
  logic [1:0][13:0] smp;
  logic [1:0]       rdy, cs, sck, mosi, clr, busy, fd;

  dac_sample_writer #(.CLK_DIV(2)) u0 (
    .clock_in(clk), .reset(rst[0]), .sample_in(smp[0]), .sample_valid(vld[0]),
    .sample_ready(rdy[0]), .dac_cs(cs[0]), .dac_sck(sck[0]), .dac_mosi(mosi[0]),
    .dac_clr(clr[0]), .busy(busy[0]), .frame_done(fd[0]));

  dac_sample_writer #(.CLK_DIV(1)) u1 (
    .clock_in(clk), .reset(rst[1]), .sample_in(smp[1]), .sample_valid(vld[1]),
    .sample_ready(rdy[1]), .dac_cs(cs[1]), .dac_sck(sck[1]), .dac_mosi(mosi[1]),
    .dac_clr(clr[1]), .busy(busy[1]), .frame_done(fd[1]));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] exp0[$];
  logic [31:0] exp1[$];
  logic [31:0] mon_exp;

  int          frames[2], edges[2], cs_cnt[2], fd_cnt[2], per_err[2], viol[2], last_rise[2];
  logic [31:0] word[2];
  logic        pcs[2], psck[2], abort[2];
  int          acc_prev, acc_delta;
  int          nf0, nf1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dv(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic logic [31:0] exp_frame(input logic [13:0] s);
    logic [11:0] code;
    code[11]   = ~s[13];
    code[10:0] = s[12:2];
    return {8'h00, 4'h3, 4'hF, code, 4'h0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input int i, input logic [31:0] e);
    if (i == 0) exp0.push_back(e);
    else        exp1.push_back(e);
  endtask

  // Capture MOSI on SCK rising edges while CS is low; score on CS rising.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (fd[i]) fd_cnt[i]++;
      if ((busy[i] && rdy[i]) || (!cs[i] && !busy[i])) viol[i]++;
      if (i == 0 && vld[0] && rdy[0]) begin
        acc_delta = cyc - acc_prev;
        acc_prev  = cyc;
      end
      if (!cs[i]) begin
        cs_cnt[i]++;
        if (sck[i] && !psck[i]) begin
          if (edges[i] > 0 && (cyc - last_rise[i]) != 2 * dv(i)) per_err[i]++;
          last_rise[i] = cyc;
          word[i]      = {word[i][30:0], mosi[i]};
          edges[i]++;
        end
      end else if (!pcs[i]) begin
        if (abort[i]) begin
          abort[i] = 1'b0;
        end else begin
          frames[i]++;
          mon_exp = 'x;
          if (i == 0 && exp0.size() > 0) mon_exp = exp0.pop_front();
          if (i == 1 && exp1.size() > 0) mon_exp = exp1.pop_front();
          chk($sformatf("u%0d_frame_word", i), word[i], mon_exp);
          chk($sformatf("u%0d_cs_low_cycles", i), cs_cnt[i], 65 * dv(i));
          chk($sformatf("u%0d_sck_rises", i), edges[i], 32);
          chk($sformatf("u%0d_frame_done_at_end", i), {31'd0, fd[i]}, 32'd1);
          chk($sformatf("u%0d_sck_period", i), per_err[i], 0);
        end
        word[i] = '0; edges[i] = 0; cs_cnt[i] = 0; per_err[i] = 0;
      end
      pcs[i]  = cs[i];
      psck[i] = sck[i];
    end
  end

  task automatic send(input int i, input logic [13:0] s, input logic [31:0] e);
    @(posedge clk); #1;
    vld[i] = 1'b1;
    smp[i] = s;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (rdy[i]) break;
    end
    chk($sformatf("u%0d_send_ready", i), {31'd0, rdy[i]}, 32'd1);
    push_exp(i, e);
    @(posedge clk); #1;
    vld[i] = 1'b0;
    smp[i] = ~s;
  endtask

  task automatic wait_frames(input int i, input int target);
    for (int n = 0; n < 1500 && frames[i] < target; n++) @(posedge clk);
    chk($sformatf("u%0d_frames_seen", i), frames[i], target);
    repeat (8) @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      frames[i] = 0; edges[i] = 0; cs_cnt[i] = 0; fd_cnt[i] = 0; per_err[i] = 0;
      viol[i] = 0; last_rise[i] = 0; word[i] = '0; pcs[i] = 1'b1; psck[i] = 1'b0;
      abort[i] = 1'b0;
    end
    acc_prev = 0; acc_delta = 0; nf0 = 0; nf1 = 0;
    rst = 2'b11; vld = 2'b00; smp = '0;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs",    {31'd0, cs[0]},   32'd1);
    chk("rst_sck",   {31'd0, sck[0]},  32'd0);
    chk("rst_clr",   {31'd0, clr[0]},  32'd0);
    chk("rst_ready", {31'd0, rdy[0]},  32'd0);
    chk("rst_mosi",  {31'd0, mosi[0]}, 32'd0);
    chk("rst_busy",  {31'd0, busy[0]}, 32'd0);
    chk("rst_done",  {31'd0, fd[0]},   32'd0);
    @(posedge clk); #1;
    rst = 2'b00;
    @(negedge clk);
    chk("rel_clr_still_low", {31'd0, clr[0]}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rel_clr",    {30'd0, clr}, 32'd3);
    chk("rel_ready",  {30'd0, rdy}, 32'd3);

    // single frame and mapping extremes
    send(0, 14'h0000, 32'h003F8000); nf0++; wait_frames(0, nf0);
    send(0, 14'h1FFF, 32'h003FFFF0); nf0++; wait_frames(0, nf0);
    send(0, 14'h2000, 32'h003F0000); nf0++; wait_frames(0, nf0);
    send(0, 14'h3FFF, 32'h003F7FF0); nf0++; wait_frames(0, nf0);

    // back-to-back with valid held and data changing every cycle
    @(negedge clk);
    chk("b2b_idle_ready", {31'd0, rdy[0]}, 32'd1);
    @(posedge clk); #1;
    for (int k = 0; k < 136; k++) begin
      logic [13:0] sv;
      sv     = 14'(k * 613 + 77);
      smp[0] = sv;
      vld[0] = 1'b1;
      if (k == 0 || k == 135) push_exp(0, exp_frame(sv));
      @(negedge clk);
      if (k == 0 || k == 135)
        chk($sformatf("b2b_ready_%0d", k), {31'd0, rdy[0]}, 32'd1);
      if (k == 1 || k == 70 || k == 134)
        chk($sformatf("b2b_not_ready_%0d", k), {31'd0, rdy[0]}, 32'd0);
      @(posedge clk); #1;
    end
    vld[0] = 1'b0;
    nf0 += 2;
    wait_frames(0, nf0);
    chk("b2b_accept_spacing", acc_delta, 135);

    // reset mid-frame, with valid asserted during reset
    send(0, 14'h1234, exp_frame(14'h1234));
    for (int n = 0; n < 400 && edges[0] < 10; n++) @(negedge clk);
    chk("mid_edges", edges[0], 10);
    abort[0] = 1'b1;
    void'(exp0.pop_back());
    @(posedge clk); #1;
    rst[0] = 1'b1; vld[0] = 1'b1; smp[0] = 14'h0AAA;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_cs",   {31'd0, cs[0]},   32'd1);
    chk("mid_rst_sck",  {31'd0, sck[0]},  32'd0);
    chk("mid_rst_done", {31'd0, fd[0]},   32'd0);
    chk("mid_rst_mosi", {31'd0, mosi[0]}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy[0]}, 32'd0);
    @(posedge clk); #1;
    rst[0] = 1'b0; vld[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("post_rst_idle_cs", {31'd0, cs[0]}, 32'd1);
    send(0, 14'h2AAA, exp_frame(14'h2AAA)); nf0++; wait_frames(0, nf0);

    // CLK_DIV = 1
    send(1, 14'h1000, 32'h003FC000); nf1++; wait_frames(1, nf1);

    chk("u0_frame_done_count", fd_cnt[0], 7);
    chk("u1_frame_done_count", fd_cnt[1], 1);
    chk("u0_ready_busy_viol", viol[0], 0);
    chk("u1_ready_busy_viol", viol[1], 0);
    chk("u0_queue_empty", exp0.size(), 0);
    chk("u1_queue_empty", exp1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_sample_writer.md
Name: dac_sample_writer

Overview:
- Downstream consumer of the ADC capture block (LTC6912 preamp / LTC1407A ADC path).
- Accepts one 14-bit signed ADC sample per valid/ready handshake and maps it to 12-bit offset-binary.
- Shifts a 32-bit write-and-update frame to the Spartan-3E on-board LTC2624 DAC over SPI.
- Completes the ADC -> DAC loopback path on the board.

Parameters:
- CLK_DIV, 2: SCK half-period in clock_in cycles, legal range 1..255. Default gives 12.5 MHz SCK from 50 MHz.
- DAC_CMD, 4'b0011: LTC2624 command nibble (write to and update channel).
- DAC_ADDR, 4'b1111: LTC2624 address nibble (all channels).

Ports:
- clock_in  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- sample_in  in  14  ADC sample, two's complement.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  block can accept a sample this cycle.
- dac_cs  out  1  DAC chip select, active low.
- dac_sck  out  1  SPI clock to DAC; DAC samples on the rising edge.
- dac_mosi  out  1  SPI data to DAC, MSB first.
- dac_clr  out  1  DAC asynchronous clear, active low.
- busy  out  1  frame in progress (cs low or gap).
- frame_done  out  1  one-cycle pulse when a frame completes.

Behaviour:
- All outputs are registered.
- Reset values: sample_ready=0, dac_cs=1, dac_sck=0, dac_mosi=0, dac_clr=0, busy=0, frame_done=0.
- Cycle after reset deasserts: dac_clr=1, sample_ready=1. dac_clr stays 1 until the next reset.
- Sample mapping: code[11:0] = {~sample_in[13], sample_in[12:2]}; the 2 LSBs are truncated.
  - 14'h0000 -> 12'h800
  - 14'h1FFF -> 12'hFFF
  - 14'h2000 -> 12'h000
- Frame (bit 31 first): {8'h00, DAC_CMD, DAC_ADDR, code, 4'h0}.
- Handshake:
  - A sample is accepted only when sample_valid && sample_ready.
  - sample_ready=1 only in IDLE.
  - Valid without ready is ignored; there is no buffering. Upstream must hold or drop the sample.
- FSM states: IDLE, SETUP, SCK_HI, SCK_LO, GAP.
  - IDLE: dac_cs=1, dac_sck=0, sample_ready=1. On accept: latch frame, go to SETUP; next cycle dac_cs=0, dac_mosi=frame[31], busy=1, sample_ready=0.
  - SETUP: D cycles (D=CLK_DIV) with dac_sck=0, then go to SCK_HI.
  - SCK_HI: dac_sck=1 for D cycles, then go to SCK_LO.
  - SCK_LO: dac_sck=0 for D cycles. On entry to SCK_LO, dac_mosi advances to the next bit; after bit 0, dac_mosi=0. After the 32nd SCK_LO, go to GAP; otherwise go to SCK_HI.
  - GAP: dac_cs=1 for 2*D cycles. frame_done=1 on the first GAP cycle only. After 2*D cycles go to IDLE, busy=0.
- Timing:
  - dac_cs low for exactly 65*D cycles (130 at default).
  - Exactly 32 SCK rising edges per frame.
  - dac_mosi stable for at least D cycles before and after each rising edge.
  - Accept-to-accept minimum is 1 + 65*D + 2*D cycles (135 at default).
- Bit counter: 5 bits plus terminal flag; no wrap into a 33rd bit.
- Divider counter reloads at every state change.
- Reset mid-frame: next cycle all outputs take reset values; the partial frame is abandoned and no frame_done is issued.
- Reset and sample_valid in the same cycle: reset wins; the sample is not accepted.
- sample_in changing after accept has no effect on the frame in flight.

Decomposition:
- Package dac_spi_pkg:
  - state encoding
  - FRAME_W=32
  - ADC_W=14
  - DAC_W=12
  - default CMD/ADDR constants
  - sample-to-code mapping function
- Sub-module spi_tx_shift32: the 32-bit shift register plus SCK half-period divider and bit counter. It is driven by load/shift strobes from the top-level FSM.

Test Plan:
- Reset: hold reset 3 cycles -> dac_cs=1, dac_sck=0, dac_clr=0, sample_ready=0. One cycle after release -> dac_clr=1, sample_ready=1.
- Single frame: sample_in=14'h0000 with valid, CLK_DIV=2 -> MOSI word captured on SCK rising edges = 32'h003F8000. dac_cs low exactly 130 cycles, 32 rising edges, frame_done pulses once.
- Mapping extremes:
  - 14'h1FFF -> 32'h003FFFF0
  - 14'h2000 -> 32'h003F0000
  - 14'h3FFF (-1) -> 32'h003F7FF0
- Back-to-back: sample_valid held high with changing data -> second accept exactly 135 cycles after the first. sample_ready=0 throughout busy. Intermediate samples are not captured.
- Reset mid-frame: assert reset after 10 SCK edges -> next cycle dac_cs=1, dac_sck=0, no frame_done. The next sample after release produces a complete, correct frame.
- CLK_DIV=1: sample 14'h1000 -> frame 32'h003FC000, dac_cs low 65 cycles, dac_sck period 2 cycles.
